// File: rtl/out_buffer.sv
// Output buffer: rdy edge capture, scale to DOUT_W, FWFT FIFO with sticky overflow.
// Define OUT_BUFFER_ROUND_EN for round-half-up with saturation; default truncates.
module out_buffer #(
    parameter int DIN_W  = 47,
    parameter int DOUT_W = 24,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DIN_W-1:0]           din,
    input  logic                       din_rdy,
    output logic [DOUT_W-1:0]          dout,
    output logic                       dout_vld,
    input  logic                       dout_ack,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovf,
    input  logic                       ovf_clr
);
    localparam int S  = DIN_W - DOUT_W;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic                rdy_q;
    logic                strobe;
    logic [DIN_W-1:0]    cap;
    logic                cap_vld;
    logic [DOUT_W-1:0]   scaled;
    logic [DOUT_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                full;
    logic                pop;
    logic                wr_ok;
    logic                drop;

    assign strobe = din_rdy & ~rdy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_q   <= 1'b0;
            cap_vld <= 1'b0;
        end else begin
            rdy_q   <= din_rdy;
            cap_vld <= strobe;
        end
    end

    // Capture register holds data only; its valid bit carries the reset.
    always_ff @(posedge clk) begin
        if (strobe) begin
            cap <= din;
        end
    end

`ifdef OUT_BUFFER_ROUND_EN
    localparam logic [DIN_W:0] HALF = (DIN_W + 1)'(1) << (S - 1);
    logic [DIN_W:0]  sum;
    logic [DOUT_W:0] shifted;
    logic            unused_lsb;

    assign sum        = {cap[DIN_W-1], cap} + HALF;
    assign shifted    = sum[DIN_W:S];
    assign unused_lsb = ^sum[S-1:0];

    // Adding half can only overflow upward.
    always_comb begin
        scaled = shifted[DOUT_W-1:0];
        if (shifted[DOUT_W] != shifted[DOUT_W-1]) begin
            scaled = {1'b0, {(DOUT_W - 1){1'b1}}};
        end
    end
`else
    logic unused_lsb;

    assign scaled     = cap[DIN_W-1:S];
    assign unused_lsb = ^cap[S-1:0];
`endif

    assign dout_vld = (level != '0);
    assign full     = (level == LW'(DEPTH));
    assign pop      = dout_vld & dout_ack;
    assign wr_ok    = cap_vld & (~full | pop);
    assign drop     = cap_vld & full & ~pop;
    assign dout     = dout_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= scaled;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({wr_ok, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end
endmodule
